// File: rtl/servo_out_pkg.sv
// Shared types and helpers for the servo DAC output stage.
package servo_out_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int DAC_CODE_W = 16;

  typedef struct packed {
    logic [DAC_CODE_W-1:0] code;
    logic [1:0]            hit;
  } dac_sample_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Rail flags win over the accumulator; then clamp into [lo, hi], with hi winning on an inverted window.
  function automatic dac_sample_t shape_sample(input logic [DAC_CODE_W-1:0] acc_hi,
                                               input logic                  ovf,
                                               input logic                  unf,
                                               input logic [DAC_CODE_W-1:0] lo,
                                               input logic [DAC_CODE_W-1:0] hi);
    logic [DAC_CODE_W-1:0] raw;
    logic [DAC_CODE_W-1:0] floored;
    dac_sample_t           s;
    if (unf)      raw = '0;
    else if (ovf) raw = '1;
    else          raw = acc_hi;
    floored  = (raw < lo) ? lo : raw;
    s.code   = (floored > hi) ? hi : floored;
    s.hit[1] = (s.code == hi) && (raw >= hi);
    s.hit[0] = (s.code == lo) && (raw <= lo);
    return s;
  endfunction

endpackage

// File: rtl/servo_dac_output_shifter.sv
// Serial DAC frame generator: divider, bit counter and shift register driving SCLK/DIN/SYNC.
module dac_spi_shifter
  import servo_out_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  done,
  output logic                  dac_sclk,
  output logic                  dac_din,
  output logic                  dac_sync_n
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int BIT_W = cnt_width(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  phase_end;

  assign phase_end = (div_cnt == DIV_LAST);
  assign done      = ~dac_sync_n & ~dac_sclk & phase_end & (bit_cnt == BIT_LAST);
  assign dac_din   = shreg[FRAME_BITS-1];

  // The final shift empties the register, so DIN naturally returns to 0 between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
    end else if (start) begin
      shreg      <= frame;
      dac_sync_n <= 1'b0;
      dac_sclk   <= 1'b1;
      div_cnt    <= '0;
      bit_cnt    <= '0;
    end else if (!dac_sync_n) begin
      if (phase_end) begin
        div_cnt  <= '0;
        dac_sclk <= ~dac_sclk;
        if (!dac_sclk) begin
          shreg <= shreg << 1;
          if (bit_cnt == BIT_LAST) dac_sync_n <= 1'b1;
          else                     bit_cnt    <= bit_cnt + BIT_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/servo_dac_output.sv
// Saturates and clamps the accumulator into a DAC code and streams it to a serial DAC, coalescing updates.
module servo_dac_output
  import servo_out_pkg::*;
#(
  parameter int                               CLK_DIV    = 2,
  parameter int                               FRAME_BITS = 24,
  parameter logic [FRAME_BITS-DAC_CODE_W-1:0] DAC_CMD    = 8'h30,
  parameter int                               SYNC_IDLE  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           accum_in,
  input  logic                  accum_overflow,
  input  logic                  accum_underflow,
  input  logic                  update,
  input  logic                  hold,
  input  logic [DAC_CODE_W-1:0] lower_limit,
  input  logic [DAC_CODE_W-1:0] upper_limit,
  output logic                  dac_sclk,
  output logic                  dac_din,
  output logic                  dac_sync_n,
  output logic [DAC_CODE_W-1:0] value_out,
  output logic [1:0]            limit_hit,
  output logic                  busy
);

  localparam int GAP_W = cnt_width(SYNC_IDLE);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_IDLE - 1);

  state_t      state, next_state;
  dac_sample_t sample_d, sample_q;
  logic        pending;
  logic        take;
  logic        start;
  logic        shift_done;
  logic        gap_last;
  logic [GAP_W-1:0] gap_cnt;
  logic        unused_accum_low;

  assign unused_accum_low = ^accum_in[15:0];
  assign take     = update & ~hold;
  assign sample_d = shape_sample(accum_in[31:16], accum_overflow, accum_underflow,
                                 lower_limit, upper_limit);
  assign gap_last = (gap_cnt == GAP_LAST);

  // A fresh sample on the consume edge re-arms pending, so it rides the next frame instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      pending  <= 1'b0;
    end else begin
      if (take) sample_q <= sample_d;
      pending <= take | (pending & ~start);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending)    next_state = SHIFT;
      SHIFT:   if (shift_done) next_state = GAP;
      GAP:     if (gap_last)   next_state = pending ? SHIFT : IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_comb begin
    start = pending & ((state == IDLE) | ((state == GAP) & gap_last));
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gap_cnt <= '0;
    else if (state != GAP)   gap_cnt <= '0;
    else                     gap_cnt <= gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_out <= '0;
      limit_hit <= '0;
    end else if (start) begin
      value_out <= sample_q.code;
      limit_hit <= sample_q.hit;
    end
  end

  dac_spi_shifter #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame      ({DAC_CMD, sample_q.code}),
    .done       (shift_done),
    .dac_sclk   (dac_sclk),
    .dac_din    (dac_din),
    .dac_sync_n (dac_sync_n)
  );

endmodule
